// File: rtl/jelly_data_width_converter_n2m.sv
// jelly_data_width_converter_n2m
// Arbitrary-ratio unit gearbox: S_UNITS units per input beat in, M_UNITS units
// per output beat out. Units are held in a FIFO-ordered buffer with per-unit
// first/last tags. A last-tagged beat closes the input until the packet tail
// (possibly a partial word) has been emitted, so packets never share a word.
module jelly_data_width_converter_n2m #(
  parameter int UNIT_WIDTH = 8,
  parameter int S_UNITS    = 3,
  parameter int M_UNITS    = 4,
  parameter int CNT_WIDTH  = $clog2(S_UNITS + 2*M_UNITS)
) (
  input  logic                          clk,
  input  logic                          reset_n,
  input  logic                          cke,
  input  logic                          endian,
  input  logic [S_UNITS*UNIT_WIDTH-1:0] s_data,
  input  logic                          s_first,
  input  logic                          s_last,
  input  logic                          s_valid,
  output logic                          s_ready,
  output logic [M_UNITS*UNIT_WIDTH-1:0] m_data,
  output logic [$clog2(M_UNITS+1)-1:0]  m_count,
  output logic                          m_first,
  output logic                          m_last,
  output logic                          m_valid,
  input  logic                          m_ready
);

  localparam int CAP = S_UNITS + 2*M_UNITS - 1;
  localparam int MCW = $clog2(M_UNITS + 1);

  typedef struct packed {
    logic                  first;
    logic                  last;
    logic [UNIT_WIDTH-1:0] data;
  } unit_t;

  unit_t                buf_q [CAP];
  unit_t                buf_d [CAP];
  logic [CNT_WIDTH-1:0] count_q;
  logic [CNT_WIDTH-1:0] count_d;
  logic                 flush_q;
  logic                 flush_d;
  logic                 active_q;

  int   count_s;
  int   pres_s;
  int   slot_s;
  int   rm_s;
  int   base_s;
  int   src_s;
  int   k_s;
  int   sel_s;
  logic accept_s;
  logic emit_s;

  // Input is closed during reset's first clock, while frozen, when the buffer
  // cannot take another beat, or while a packet tail is draining.
  assign s_ready  = active_q && cke && (count_q < CNT_WIDTH'(2*M_UNITS)) && !flush_q;
  assign accept_s = s_valid && s_ready;
  assign emit_s   = cke && m_valid && m_ready;

  // Output word decode: the oldest min(count, M_UNITS) units, zero elsewhere.
  always_comb begin
    count_s = int'(count_q);
    m_valid = (count_s >= M_UNITS) || (flush_q && (count_s > 0));
    pres_s  = m_valid ? ((count_s >= M_UNITS) ? M_UNITS : count_s) : 0;
    m_count = MCW'(pres_s);
    m_data  = '0;
    m_first = 1'b0;
    m_last  = 1'b0;
    slot_s  = 0;
    for (int k = 0; k < M_UNITS; k++) begin
      slot_s = endian ? (M_UNITS - 1 - k) : k;
      m_data[slot_s*UNIT_WIDTH +: UNIT_WIDTH] = (k < pres_s) ? buf_q[k].data : '0;
      m_first = m_first | (buf_q[k].first & (k < pres_s));
      m_last  = m_last  | (buf_q[k].last  & (k < pres_s));
    end
  end

  // Next buffer: drop the emitted head units, shift the rest down, append the
  // accepted beat right behind the surviving units.
  always_comb begin
    rm_s    = emit_s ? pres_s : 0;
    base_s  = count_s - rm_s;
    src_s   = 0;
    k_s     = 0;
    sel_s   = 0;
    buf_d   = '{default: '0};
    for (int i = 0; i < CAP; i++) begin
      src_s = i + rm_s;
      k_s   = i - base_s;
      sel_s = endian ? (S_UNITS - 1 - k_s) : k_s;
      if (src_s < count_s) begin
        buf_d[i] = buf_q[src_s];
      end else if (accept_s && (k_s >= 0) && (k_s < S_UNITS)) begin
        buf_d[i].data  = s_data[sel_s*UNIT_WIDTH +: UNIT_WIDTH];
        buf_d[i].first = s_first && (k_s == 0);
        buf_d[i].last  = s_last && (k_s == S_UNITS - 1);
      end else begin
        buf_d[i] = '0;
      end
    end
    count_d = CNT_WIDTH'(base_s + (accept_s ? S_UNITS : 0));
    if (accept_s && s_last) begin
      flush_d = 1'b1;
    end else if (emit_s && m_last) begin
      flush_d = 1'b0;
    end else begin
      flush_d = flush_q;
    end
  end

  // State registers: cleared asynchronously, advanced only on clock enable.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < CAP; i++) begin
        buf_q[i] <= '0;
      end
      count_q  <= '0;
      flush_q  <= 1'b0;
      active_q <= 1'b0;
    end else begin
      active_q <= 1'b1;
      if (cke) begin
        buf_q   <= buf_d;
        count_q <= count_d;
        flush_q <= flush_d;
      end
    end
  end

endmodule
